// File: rtl/johnson_pkg.sv
// Shared types and ring helpers for the Johnson sequencer.
// Ring width is fixed here; the modules take their default widths from these values.
package johnson_pkg;

   localparam int JOHNSON_WIDTH = 4;
   localparam int JOHNSON_CNT_W = 8;

   typedef enum logic [1:0] {IDLE, RUN, RECOVER} seq_state_t;
   typedef logic [JOHNSON_WIDTH-1:0]   ring_t;
   typedef logic [2*JOHNSON_WIDTH-1:0] phase_t;

   function automatic ring_t johnson_next(input ring_t q, input logic dir);
      if (dir)
         return {~q[0], q[JOHNSON_WIDTH-1:1]};
      else
         return {q[JOHNSON_WIDTH-2:0], ~q[JOHNSON_WIDTH-1]};
   endfunction

   // A legal Johnson pattern has at most one boundary between adjacent differing bits.
   function automatic logic johnson_legal(input ring_t q);
      int edges;
      edges = 0;
      for (int i = 0; i < JOHNSON_WIDTH-1; i++)
         if (q[i] != q[i+1]) edges = edges + 1;
      return (edges <= 1);
   endfunction

   function automatic phase_t johnson_phase(input ring_t q);
      int ones;
      int k;
      phase_t onehot;
      ones = 0;
      for (int i = 0; i < JOHNSON_WIDTH; i++)
         ones = ones + int'(q[i]);
      k = q[JOHNSON_WIDTH-1] ? (2*JOHNSON_WIDTH - ones) : ones;
      onehot = '0;
      if (johnson_legal(q))
         onehot = phase_t'(1) << k;
      return onehot;
   endfunction

endpackage

// File: rtl/johnson_seq_ctrl_if.sv
// Command and status bundle between the Johnson sequencer and its controller.
interface johnson_seq_ctrl_if
   import johnson_pkg::*;
#(
   parameter int WIDTH = JOHNSON_WIDTH,
   parameter int CNT_W = JOHNSON_CNT_W
);
   logic               start;
   logic               stop;
   logic               step;
   logic               dir;
   logic [CNT_W-1:0]   run_len;
   logic               load;
   logic [WIDTH-1:0]   load_val;
   logic               err_clr;
   logic [WIDTH-1:0]   q;
   logic [2*WIDTH-1:0] phase;
   logic               busy;
   logic               done;
   logic               err;

   modport master (
      output start, stop, step, dir, run_len, load, load_val, err_clr,
      input  q, phase, busy, done, err
   );

   modport slave (
      input  start, stop, step, dir, run_len, load, load_val, err_clr,
      output q, phase, busy, done, err
   );

endinterface

// File: rtl/johnson_decode.sv
// Combinational legality check and one-hot phase decode of the ring value.
module johnson_decode
   import johnson_pkg::*;
(
   input  ring_t  q,
   output logic   legal,
   output phase_t phase
);

   assign legal = johnson_legal(q);
   assign phase = johnson_phase(q);

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Johnson ring sequencer: run/step/load control, bounded runs and illegal-state recovery.
module johnson_seq_ctrl
   import johnson_pkg::*;
#(
   parameter int WIDTH = JOHNSON_WIDTH,
   parameter int CNT_W = JOHNSON_CNT_W
)(
   input logic               clk,
   input logic               clr,
   johnson_seq_ctrl_if.slave bus
);

   seq_state_t         state, state_next;
   logic [WIDTH-1:0]   q, q_next;
   logic [CNT_W-1:0]   count, count_next;
   logic [CNT_W-1:0]   run_len_q, run_len_next;
   logic               busy, busy_next;
   logic               done, done_next;
   logic               err, err_next;
   logic               legal;
   logic [2*WIDTH-1:0] phase;

   johnson_decode u_decode (
      .q     (q),
      .legal (legal),
      .phase (phase)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state     <= IDLE;
         q         <= '0;
         count     <= '0;
         run_len_q <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_next;
         q         <= q_next;
         count     <= count_next;
         run_len_q <= run_len_next;
         busy      <= busy_next;
         done      <= done_next;
         err       <= err_next;
      end
   end

   // An illegal ring pre-empts every command; the following edge parks the ring at zero.
   always_comb begin
      state_next   = state;
      q_next       = q;
      count_next   = count;
      run_len_next = run_len_q;
      done_next    = 1'b0;
      err_next     = err;

      if (bus.err_clr)
         err_next = 1'b0;

      if (state == RECOVER) begin
         q_next     = '0;
         state_next = IDLE;
      end else if (!legal) begin
         state_next = RECOVER;
         err_next   = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (bus.stop) begin
                  state_next = IDLE;
               end else begin
                  q_next     = johnson_next(q, bus.dir);
                  count_next = count + 1'b1;
                  if (run_len_q != '0 && count_next == run_len_q) begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end
               end
            end
            default: begin
               if (!bus.stop) begin
                  if (bus.start) begin
                     state_next   = RUN;
                     run_len_next = bus.run_len;
                     count_next   = '0;
                  end else if (bus.load) begin
                     q_next = bus.load_val;
                  end else if (bus.step) begin
                     q_next = johnson_next(q, bus.dir);
                  end
               end
            end
         endcase
      end

      busy_next = (state_next == RUN);
   end

   assign bus.q     = q;
   assign bus.phase = phase;
   assign bus.busy  = busy;
   assign bus.done  = done;
   assign bus.err   = err;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed vector bench for johnson_seq_ctrl with a mid-run asynchronous reset sequence.
module tb_johnson_seq_ctrl;

   typedef struct {
      logic       start;
      logic       stop;
      logic       step;
      logic       dir;
      logic       load;
      logic [3:0] load_val;
      logic [7:0] run_len;
      logic       err_clr;
      logic [3:0] exp_q;
      logic [7:0] exp_phase;
      logic       exp_busy;
      logic       exp_done;
      logic       exp_err;
   } vec_t;

   logic clk;
   logic clr;
   int   compared;
   int   failed;
   vec_t vecs[$];

   johnson_seq_ctrl_if #(.WIDTH(4), .CNT_W(8)) bus ();

   johnson_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input int st, input int sp, input int stp, input int d,
                               input int ld, input int lv, input int rl, input int ec,
                               input int eq, input int eph, input int eb, input int ed,
                               input int ee);
      vec_t v;
      v.start     = 1'(st);
      v.stop      = 1'(sp);
      v.step      = 1'(stp);
      v.dir       = 1'(d);
      v.load      = 1'(ld);
      v.load_val  = 4'(lv);
      v.run_len   = 8'(rl);
      v.err_clr   = 1'(ec);
      v.exp_q     = 4'(eq);
      v.exp_phase = 8'(eph);
      v.exp_busy  = 1'(eb);
      v.exp_done  = 1'(ed);
      v.exp_err   = 1'(ee);
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      compared++;
      if (actual !== expected) begin
         failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.start    = v.start;
      bus.stop     = v.stop;
      bus.step     = v.step;
      bus.dir      = v.dir;
      bus.load     = v.load;
      bus.load_val = v.load_val;
      bus.run_len  = v.run_len;
      bus.err_clr  = v.err_clr;
   endtask

   task automatic stepAndCheck(input vec_t v, input string tag);
      applyStimulus(v);
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, ".q"},     16'(bus.q),     16'(v.exp_q));
      checkOutput({tag, ".phase"}, 16'(bus.phase), 16'(v.exp_phase));
      checkOutput({tag, ".busy"},  16'(bus.busy),  16'(v.exp_busy));
      checkOutput({tag, ".done"},  16'(bus.done),  16'(v.exp_done));
      checkOutput({tag, ".err"},   16'(bus.err),   16'(v.exp_err));
   endtask

   initial begin
      compared = 0;
      failed   = 0;

      //                 st sp sx d ld lv       rl ec  q        phase busy done err
      // bounded forward run of 3
      vecs.push_back(mk(1, 0, 0, 0, 0, 'b0000, 3, 0, 'b0000, 'h01, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 'b0000, 0, 0, 'b0001, 'h02, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 'b0000, 0, 0, 'b0011, 'h04, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 'b0000, 0, 0, 'b0111, 'h08, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 'b0000, 0, 0, 'b0111, 'h08, 0, 0, 0));
      // free-running reverse run, then STOP
      vecs.push_back(mk(0, 0, 0, 1, 1, 'b0000, 0, 0, 'b0000, 'h01, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 0, 'b0000, 0, 0, 'b0000, 'h01, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 'b0000, 0, 0, 'b1000, 'h80, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 'b0000, 0, 0, 'b1100, 'h40, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 'b0000, 0, 0, 'b1110, 'h20, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 'b0000, 0, 0, 'b1111, 'h10, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 'b0000, 0, 0, 'b0111, 'h08, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 'b0000, 0, 0, 'b0011, 'h04, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 'b0000, 0, 0, 'b0001, 'h02, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 'b0000, 0, 0, 'b0000, 'h01, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 'b0000, 0, 0, 'b1000, 'h80, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 'b0000, 0, 0, 'b1100, 'h40, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 'b0000, 0, 0, 'b1100, 'h40, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 'b0000, 0, 0, 'b1100, 'h40, 0, 0, 0));
      // load and single steps in IDLE
      vecs.push_back(mk(0, 0, 0, 0, 1, 'b1110, 0, 0, 'b1110, 'h20, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 'b0000, 0, 0, 'b1100, 'h40, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 'b0000, 0, 0, 'b1110, 'h20, 0, 0, 0));
      // illegal load, recovery (START ignored in RECOVER), ERR set beats ERR_CLR
      vecs.push_back(mk(0, 0, 0, 0, 1, 'b0101, 0, 0, 'b0101, 'h00, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 'b0000, 0, 0, 'b0101, 'h00, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 'b0000, 3, 0, 'b0000, 'h01, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 'b0000, 0, 0, 'b0000, 'h01, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 'b0101, 0, 0, 'b0101, 'h00, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 'b0000, 0, 1, 'b0101, 'h00, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 'b0000, 0, 0, 'b0000, 'h01, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 'b0000, 0, 1, 'b0000, 'h01, 0, 0, 0));
      // command priority in IDLE, LOAD ignored in RUN, run length of 1
      vecs.push_back(mk(1, 1, 0, 0, 0, 'b0000, 2, 0, 'b0000, 'h01, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 'b0000, 0, 0, 'b0000, 'h01, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 1, 'b0111, 2, 0, 'b0000, 'h01, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 'b0111, 0, 0, 'b0001, 'h02, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 'b0000, 0, 0, 'b0011, 'h04, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 'b0000, 0, 0, 'b0011, 'h04, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 'b0000, 0, 0, 'b0011, 'h04, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 'b0000, 1, 0, 'b0011, 'h04, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 'b0000, 0, 0, 'b0111, 'h08, 0, 1, 0));

      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      clr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset.q",     16'(bus.q),     16'h0000);
      checkOutput("reset.phase", 16'(bus.phase), 16'h0001);
      checkOutput("reset.busy",  16'(bus.busy),  16'h0000);
      checkOutput("reset.done",  16'(bus.done),  16'h0000);
      checkOutput("reset.err",   16'(bus.err),   16'h0000);
      clr = 1'b1;

      foreach (vecs[i])
         stepAndCheck(vecs[i], $sformatf("v%0d", i));

      // Set ERR, then start a 5-advance run and reset it asynchronously after two advances
      stepAndCheck(mk(0, 0, 0, 0, 1, 'b0101, 0, 0, 'b0101, 'h00, 0, 0, 0), "h0");
      stepAndCheck(mk(0, 0, 0, 0, 0, 'b0000, 0, 0, 'b0101, 'h00, 0, 0, 1), "h1");
      stepAndCheck(mk(0, 0, 0, 0, 0, 'b0000, 0, 0, 'b0000, 'h01, 0, 0, 1), "h2");
      stepAndCheck(mk(1, 0, 0, 0, 0, 'b0000, 5, 0, 'b0000, 'h01, 1, 0, 1), "h3");
      stepAndCheck(mk(0, 0, 0, 0, 0, 'b0000, 0, 0, 'b0001, 'h02, 1, 0, 1), "h4");
      stepAndCheck(mk(0, 0, 0, 0, 0, 'b0000, 0, 0, 'b0011, 'h04, 1, 0, 1), "h5");
      #2 clr = 1'b0;
      #1;
      checkOutput("arst.q",     16'(bus.q),     16'h0000);
      checkOutput("arst.phase", 16'(bus.phase), 16'h0001);
      checkOutput("arst.busy",  16'(bus.busy),  16'h0000);
      checkOutput("arst.err",   16'(bus.err),   16'h0000);
      @(negedge clk);
      clr = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("post%0d.done", c), 16'(bus.done), 16'h0000);
         checkOutput($sformatf("post%0d.q", c),    16'(bus.q),    16'h0000);
         checkOutput($sformatf("post%0d.busy", c), 16'(bus.busy), 16'h0000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
Sequencer for a WIDTH-stage Johnson (twisted-ring) counter. It owns the ring register and adds:
- start/stop/single-step control
- bounded or free-running runs, in either direction
- parallel load
- one-hot phase decode
- illegal-state detection with forced recovery to all-zeros

Downstream logic uses PHASE as a 2*WIDTH-slot time-division schedule.

Parameters:
WIDTH, 4, number of ring stages (>=2); sequence length 2*WIDTH
CNT_W, 8, width of run-length counter

Ports:
CLK  in  1  clock, rising edge
CLR  in  1  asynchronous active-low reset
START  in  1  begin run (sampled in IDLE only)
STOP  in  1  abort run
STEP  in  1  single advance (IDLE only)
DIR  in  1  0 = forward (shift toward MSB, ~MSB into bit0); 1 = reverse (shift toward LSB, ~bit0 into MSB)
RUN_LEN  in  CNT_W  advances per run; 0 = free-run until STOP
LOAD  in  1  parallel load (IDLE only)
LOAD_VAL  in  WIDTH  value for LOAD
ERR_CLR  in  1  clear sticky ERR
Q  out  WIDTH  ring state
PHASE  out  2*WIDTH  one-hot phase index of Q (combinational from Q)
BUSY  out  1  high while in RUN
DONE  out  1  one-cycle pulse at bounded-run completion
ERR  out  1  sticky illegal-state flag

Behaviour:
- Reset (CLR=0, async) forces: Q=0, state IDLE, count=0, BUSY=0, DONE=0, ERR=0. PHASE=1 (bit0). Reset mid-run aborts immediately; no DONE.
- Ring advance:
  - Forward: Q<={Q[W-2:0],~Q[W-1]}. For W=4 from 0000: 0001,0011,0111,1111,1110,1100,1000,0000.
  - Reverse: Q<={~Q[0],Q[W-1:1]}.
  - DIR is sampled on every advancing edge.
- Legality: Q is legal iff at most one i in 0..W-2 has Q[i]!=Q[i+1].
- Phase index k:
  - Q[W-1]=0: k=popcount(Q).
  - Q[W-1]=1: k=2W-popcount(Q).
  - PHASE[k]=1. PHASE=0 when Q is illegal.
- States: IDLE, RUN, RECOVER.
- IDLE, command priority STOP > START > LOAD > STEP:
  - STOP: no action.
  - START: go to RUN; capture RUN_LEN; count=0. Q does not move this edge.
  - LOAD: Q<=LOAD_VAL.
  - STEP: one advance.
- RUN:
  - Each edge: advance; count++.
  - If RUN_LEN!=0 and count+1==RUN_LEN: this edge performs the final advance, state goes to IDLE, DONE=1 for the following cycle.
  - STOP: go to IDLE; no advance that edge; no DONE.
  - START, LOAD and STEP are ignored.
  - Latency: START seen at edge k gives advances at edges k+1..k+RUN_LEN. BUSY is high for exactly RUN_LEN cycles.
  - Free-run count wraps silently.
- RECOVER:
  - Entered from any state on the edge after Q becomes illegal (registered check).
  - That edge: ERR<=1, BUSY<=0. Any run is aborted with no DONE.
  - Next edge: Q<=0, state goes to IDLE.
  - All commands are ignored while in RECOVER.
- ERR:
  - Set by illegal-state detection.
  - Cleared by ERR_CLR; a new set in the same cycle wins.
- DONE and BUSY are registered. Q, PHASE and ERR never glitch beyond normal combinational decode of Q.

Decomposition:
- Shared package johnson_pkg:
  - state enum (IDLE, RUN, RECOVER)
  - functions johnson_next(q, dir), johnson_legal(q), johnson_phase(q), parameterised by WIDTH via localparam
- One sub-module, johnson_decode: combinational legality plus one-hot phase, instantiated once. The controller FSM/counter stays in the top.

Test Plan:
1. Reset; DIR=0, RUN_LEN=3, pulse START -> Q=0001,0011,0111 on successive edges; BUSY high 3 cycles; DONE high one cycle after the 0111 edge; PHASE=0x08 at end.
2. DIR=1, RUN_LEN=0, START, 10 cycles -> Q=1000,1100,1110,1111,0111,0011,0001,0000,1000,1100; then STOP -> Q holds 1100, BUSY=0, DONE never asserted.
3. IDLE: LOAD 1110 -> PHASE=0x20; STEP with DIR=0 -> Q=1100, PHASE=0x40; STEP with DIR=1 -> Q=1110.
4. LOAD 0101 -> ERR=1 next edge, Q=0000 following edge, state IDLE. ERR_CLR concurrent with a fresh illegal load -> ERR stays 1. ERR_CLR alone -> ERR=0.
5. START RUN_LEN=5; drop CLR after 2 advances -> Q=0000, BUSY=0, ERR=0 immediately (before next edge); no DONE after release.
6. IDLE: STOP+START same cycle -> stays IDLE. START+LOAD same cycle -> RUN entered, LOAD ignored, Q unchanged at that edge.
